// File: rtl/target_round_ctrl_pkg.sv
// Shared types and constants for the click-accuracy game round controller.
package target_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPAWN   = 3'd1,
    ACTIVE  = 3'd2,
    RESOLVE = 3'd3,
    CHECK   = 3'd4,
    OVER    = 3'd5
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/target_round_ctrl_if.sv
// Player-input and display-side signals of the round controller.
interface target_round_ctrl_if;

  logic        start;
  logic        mouse_click;
  logic        accurate_clck;
  logic [10:0] square_x0;
  logic [10:0] square_y0;
  logic        target_visible;
  logic [7:0]  score;
  logic [7:0]  misses;
  logic        hit_pulse;
  logic        miss_pulse;
  logic        game_over;

  modport master (
    output start, mouse_click, accurate_clck,
    input  square_x0, square_y0, target_visible, score, misses,
           hit_pulse, miss_pulse, game_over
  );

  modport slave (
    input  start, mouse_click, accurate_clck,
    output square_x0, square_y0, target_visible, score, misses,
           hit_pulse, miss_pulse, game_over
  );

endinterface

// File: rtl/target_round_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the target position source.
module lfsr16
  import target_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign lfsr = r_lfsr;

endmodule

// File: rtl/target_round_ctrl.sv
// Game-round FSM: spawns targets, scores hits/misses from accurate_click and ends the game.
module target_round_ctrl
  import target_pkg::*;
#(
  parameter int SIZE           = 10,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int MAX_ROUNDS     = 20,
  parameter int MAX_MISSES     = 5
)(
  input  logic          clk,
  input  logic          reset,
  target_round_ctrl_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [10:0]   X_MAX  = 11'(SCREEN_W - 1 - SIZE);
  localparam logic [10:0]   Y_MAX  = 11'(SCREEN_H - 1 - SIZE);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_M  = 8'(MAX_MISSES);
  localparam logic [7:0]    MAX_R  = 8'(MAX_ROUNDS);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [15:0]   w_lfsr;
  logic [10:0]   w_cand_x, w_cand_y;
  logic          w_cand_ok;

  state_t        r_state, w_state_nxt;
  logic [10:0]   r_x, r_y, w_x_nxt, w_y_nxt;
  logic [7:0]    r_score, r_misses, r_round;
  logic [7:0]    w_score_nxt, w_misses_nxt, w_round_nxt;
  logic [TW-1:0] r_tcnt, w_tcnt_nxt;
  logic          r_hit, r_miss, w_hit_nxt, w_miss_nxt;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (w_lfsr)
  );

  assign w_cand_x  = {1'b0, w_lfsr[9:0]};
  assign w_cand_y  = {2'b0, w_lfsr[15:7]};
  assign w_cand_ok = (w_cand_x <= X_MAX) && (w_cand_y <= Y_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_score  <= '0;
      r_misses <= '0;
      r_round  <= '0;
      r_tcnt   <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_score  <= w_score_nxt;
      r_misses <= w_misses_nxt;
      r_round  <= w_round_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_hit    <= w_hit_nxt;
      r_miss   <= w_miss_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_score_nxt  = r_score;
    w_misses_nxt = r_misses;
    w_round_nxt  = r_round;
    w_tcnt_nxt   = r_tcnt;
    w_hit_nxt    = 1'b0;
    w_miss_nxt   = 1'b0;
    case (r_state)
      IDLE, OVER: begin
        if (bus.start) begin
          w_score_nxt  = '0;
          w_misses_nxt = '0;
          w_round_nxt  = '0;
          w_state_nxt  = SPAWN;
        end
      end
      SPAWN: begin
        // Out-of-range candidates are rejected so the whole square stays on screen
        if (w_cand_ok) begin
          w_x_nxt     = w_cand_x;
          w_y_nxt     = w_cand_y;
          w_tcnt_nxt  = '0;
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (r_tcnt != T_LAST) w_tcnt_nxt = r_tcnt + 1'b1;
        if (bus.mouse_click) begin
          w_state_nxt = RESOLVE;
        end else if (r_tcnt == T_LAST) begin
          w_miss_nxt   = 1'b1;
          w_misses_nxt = sat_inc8(r_misses);
          w_round_nxt  = sat_inc8(r_round);
          w_state_nxt  = CHECK;
        end
      end
      RESOLVE: begin
        if (bus.accurate_clck) begin
          w_hit_nxt   = 1'b1;
          w_score_nxt = sat_inc8(r_score);
        end else begin
          w_miss_nxt   = 1'b1;
          w_misses_nxt = sat_inc8(r_misses);
        end
        w_round_nxt = sat_inc8(r_round);
        w_state_nxt = CHECK;
      end
      CHECK: begin
        if ((r_misses == MAX_M) || (r_round == MAX_R)) w_state_nxt = OVER;
        else                                           w_state_nxt = SPAWN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.square_x0      = r_x;
  assign bus.square_y0      = r_y;
  assign bus.target_visible = (r_state == ACTIVE) || (r_state == RESOLVE);
  assign bus.score          = r_score;
  assign bus.misses         = r_misses;
  assign bus.hit_pulse      = r_hit;
  assign bus.miss_pulse     = r_miss;
  assign bus.game_over      = (r_state == OVER);

endmodule

// File: doc/target_round_ctrl.md
Name: target_round_ctrl

Overview:
- Game-round controller for the click-accuracy game.
- Upstream of accurate_click: spawns the target square position (square_x0/square_y0) from an LFSR.
- Downstream of accurate_click: consumes its registered hit result (accurate_clck) to score hits, count misses, enforce a per-target timeout and end the game.
- Sits between mouse input/VGA drawing logic and the score display.

Parameters:
- SIZE, 10, target square edge length in pixels; must match accurate_click SIZE.
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- TIMEOUT_CYCLES, 50000000, cycles a target stays up before it counts as a miss.
- MAX_ROUNDS, 20, resolved targets per game.
- MAX_MISSES, 5, misses that end the game early.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  level; starts a game from IDLE or OVER
- mouse_click  in  1  one-cycle click pulse (same signal fed to accurate_click)
- accurate_clck  in  1  registered hit result from accurate_click, valid the cycle after mouse_click
- square_x0  out  11  target left x
- square_y0  out  11  target top y
- target_visible  out  1  high while in ACTIVE or RESOLVE
- score  out  8  hits this game
- misses  out  8  misses this game
- hit_pulse  out  1  one cycle per scored hit
- miss_pulse  out  1  one cycle per miss
- game_over  out  1  high in OVER

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - LFSR = 16'hACE1.
  - Timeout counter and round counter 0.
- Reset has priority over every other input, including mid-round.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts every cycle in every state except reset.
  - Candidate x = {1'b0, lfsr[9:0]}; candidate y = {2'b0, lfsr[15:7]}.
- States:
  - IDLE: outputs held. If start, clear score, misses and round counter, then go to SPAWN.
  - SPAWN: If candidate x <= SCREEN_W-1-SIZE and candidate y <= SCREEN_H-1-SIZE, register it into square_x0/y0, clear the timeout counter and go to ACTIVE. Otherwise stay in SPAWN and retry next cycle. The whole square is always on screen.
  - ACTIVE:
    - square_x0/y0 held constant; the timeout counter increments each cycle.
    - If mouse_click, go to RESOLVE. A click wins over a timeout in the same cycle.
    - Else if counter == TIMEOUT_CYCLES-1: miss_pulse, misses+1, round+1, go to CHECK.
  - RESOLVE: exactly one cycle; mouse_click ignored.
    - If accurate_clck: hit_pulse, score+1.
    - Else: miss_pulse, misses+1.
    - round+1 in both cases; go to CHECK.
  - CHECK: one cycle.
    - If misses == MAX_MISSES or round == MAX_ROUNDS, go to OVER.
    - Else go to SPAWN.
  - OVER: game_over=1; score, misses and square held. If start, clear counters and go to SPAWN.
- Click latency: click pulse at edge N → hit/miss pulse and counter update visible after edge N+2.
- Counter widths:
  - score and misses saturate at 255 (unreachable with defaults).
  - Round counter is 8 bits.
  - Timeout counter is $clog2(TIMEOUT_CYCLES) bits and never wraps.
- mouse_click in IDLE, SPAWN, CHECK or OVER is ignored.

Decomposition:
- Package target_pkg:
  - state enum {IDLE, SPAWN, ACTIVE, RESOLVE, CHECK, OVER}.
  - LFSR_SEED = 16'hACE1 and the LFSR tap mask.
- Sub-module lfsr16: clk and reset in, 16-bit value out, seeded from the package.
- FSM, counters and bounds check stay in target_round_ctrl.

Test Plan:
- Reset then start=1 for one cycle → after SPAWN, square_x0 <= 629 and square_y0 <= 469, matching the bench's LFSR reference model; score=0, misses=0.
- TIMEOUT_CYCLES=8, accurate_clck driven 1 the cycle after each click, click on the 3rd ACTIVE cycle → hit_pulse 2 cycles after the click, score=1, new target spawned.
- TIMEOUT_CYCLES=8, no click → miss_pulse exactly 8 cycles after entering ACTIVE, misses=1.
- Click coincident with the final timeout cycle and accurate_clck=1 → scored as a hit, no miss_pulse.
- MAX_MISSES=5, 5 clicks with accurate_clck=0 → game_over=1, misses=5; further clicks change nothing; start → counters cleared, SPAWN.
- Reset asserted while in ACTIVE with score=3 → next cycle IDLE, all outputs 0; LFSR sequence restarts from 16'hACE1.
